ch_readout_deser: RTL

- Controller and deserializer on the receiving end of the per-channel serial readout link.
- Sequences the register-select code and readout command into one PSEC6 channel digital block.
- Samples the returned CNT_SER bit stream and reassembles the six readout words: CA, CB, CC, CD, CE and trigger count.
- Presents each word on a parallel valid/ready interface to the chip-level readout collector.

---
 rtl/ch_readout_deser.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ch_readout_deser.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : ch_readout_deser
// Description : Readout controller and deserializer for one PSEC6 channel.
//               For each register it drives the select code, pulses the
//               readout command, shifts in the MSB-first CNT_SER stream and
//               presents the word on a valid/ready interface. One sweep
//               reads select codes 0..NUM_REGS-1.
// Ports       : SPI_CLK      readout clock, the only clock
//               RST          synchronous active-high reset
//               START_READ   pulse, starts a sweep (ignored while busy)
//               ABORT        return to idle at next edge, discarding data
//               CNT_SER      serial data from the channel, MSB first
//               SELECT_REG   register select code to the channel
//               INST_READOUT one-cycle load/readout command to the channel
//               DATA_OUT     assembled word
//               DATA_SEL     select code of the word on DATA_OUT
//               DATA_VALID   DATA_OUT/DATA_SEL valid
//               DATA_READY   consumer accepts word when high with DATA_VALID
//               BUSY         sweep in progress
//               DONE         one-cycle pulse after last word accepted
//               FORMAT_ERR   sticky, trigger-count word had stray high bits
// Revision    : 1.0 - initial release
// ============================================================================
module ch_readout_deser #(
    parameter int WORD_W   = 10,
    parameter int NUM_REGS = 6,
    parameter int LOAD_LAT = 1,
    parameter int TCNT_SEL = 5
) (
    input  logic              SPI_CLK,
    input  logic              RST,
    input  logic              START_READ,
    input  logic              ABORT,
    input  logic              CNT_SER,
    output logic [2:0]        SELECT_REG,
    output logic              INST_READOUT,
    output logic [WORD_W-1:0] DATA_OUT,
    output logic [2:0]        DATA_SEL,
    output logic              DATA_VALID,
    input  logic              DATA_READY,
    output logic              BUSY,
    output logic              DONE,
    output logic              FORMAT_ERR
);

    // Shared counter for the WAIT latency and the SHIFT bit count.
    localparam int c_CNT_W = $clog2(WORD_W + LOAD_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_LAST_BIT  = c_CNT_W'(WORD_W - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_WAIT = c_CNT_W'((LOAD_LAT > 0) ? LOAD_LAT - 1 : 0);
    localparam logic [2:0]         c_LAST_IDX  = 3'(NUM_REGS - 1);
    localparam logic [2:0]         c_TCNT_SEL  = 3'(TCNT_SEL);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_SEL     = 3'd1;
    localparam logic [2:0] c_LOAD    = 3'd2;
    localparam logic [2:0] c_WAIT    = 3'd3;
    localparam logic [2:0] c_SHIFT   = 3'd4;
    localparam logic [2:0] c_PRESENT = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [2:0]         r_index;
    logic [c_CNT_W-1:0] r_cnt;
    // Only WORD_W-1 bits are kept: the final bit goes straight into r_data.
    logic [WORD_W-2:0]  r_shift;
    logic [WORD_W-1:0]  w_shift_next;
    logic [WORD_W-1:0]  r_data;
    logic               r_done;
    logic               r_fmt_err;
    logic               w_start;
    logic               w_abort;
    logic               w_accept;

    assign w_shift_next = {r_shift, CNT_SER};
    // A start that lands on the DONE cycle is dropped; caller re-pulses.
    assign w_start  = (r_state == c_IDLE) && START_READ && !r_done;
    assign w_abort  = ABORT && (r_state != c_IDLE);
    // ABORT wins over a simultaneous acceptance.
    assign w_accept = (r_state == c_PRESENT) && DATA_READY && !ABORT;

    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (w_start) w_state_next = c_SEL;
            c_SEL:     w_state_next = c_LOAD;
            c_LOAD:    w_state_next = (LOAD_LAT == 0) ? c_SHIFT : c_WAIT;
            c_WAIT:    if (r_cnt == c_LAST_WAIT) w_state_next = c_SHIFT;
            c_SHIFT:   if (r_cnt == c_LAST_BIT) w_state_next = c_PRESENT;
            c_PRESENT: begin
                if (w_accept) begin
                    w_state_next = (r_index == c_LAST_IDX) ? c_IDLE : c_SEL;
                end
            end
            default:   w_state_next = c_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = c_IDLE;
        end
    end

    always_ff @(posedge SPI_CLK) begin
        if (RST) begin
            r_index   <= '0;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_fmt_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_index <= '0;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        if (w_start) begin
                            r_index   <= '0;
                            r_fmt_err <= 1'b0;
                        end
                    end
                    c_SEL, c_LOAD: r_cnt <= '0;
                    c_WAIT: begin
                        r_cnt <= (r_cnt == c_LAST_WAIT) ? '0 : r_cnt + c_CNT_W'(1);
                    end
                    c_SHIFT: begin
                        r_shift <= w_shift_next[WORD_W-2:0];
                        r_cnt   <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_LAST_BIT) begin
                            r_data <= w_shift_next;
                            // Trigger count is only 3 bits wide; anything above is corrupt.
                            if ((r_index == c_TCNT_SEL) && (|w_shift_next[WORD_W-1:3])) begin
                                r_fmt_err <= 1'b1;
                            end
                        end
                    end
                    c_PRESENT: begin
                        if (DATA_READY) begin
                            if (r_index == c_LAST_IDX) begin
                                r_done  <= 1'b1;
                                r_index <= '0;
                            end else begin
                                r_index <= r_index + 3'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign SELECT_REG   = (r_state == c_IDLE) ? 3'd0 : r_index;
    assign INST_READOUT = (r_state == c_LOAD);
    assign DATA_OUT     = r_data;
    assign DATA_SEL     = r_index;
    assign DATA_VALID   = (r_state == c_PRESENT);
    assign BUSY         = (r_state != c_IDLE);
    assign DONE         = r_done;
    assign FORMAT_ERR   = r_fmt_err;

endmodule
`default_nettype wire
